div_issue_ctrl: RTL and testbench
=================================

# div_issue_ctrl

- Initiator side of the EX-stage divider handshake.
- Accepts LoongArch 32-bit divide/modulo ops (div.w, mod.w, div.wu, mod.wu) from EX.
- Converts signed operands to magnitudes, drives the unsigned iterative divider through en/ready/flush_exception, sign-corrects the result, and stalls the pipeline until the result is available.
- Also handles divide-by-zero bypass and exception-flush abort, so the divider is always left in its idle state.

## Interface

Parameters: none.

- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- ex_div_valid  in  1  EX holds a divide/modulo op
- ex_op  in  2  00 div.w, 01 mod.w, 10 div.wu, 11 mod.wu
- ex_src1  in  32  dividend
- ex_src2  in  32  divisor
- flush  in  1  pipeline exception flush
- stall  out  1  hold EX; combinational = ex_div_valid & ~flush & ~result_valid
- result  out  32  sign-corrected quotient or remainder
- result_valid  out  1  one-cycle pulse; result valid
- div_dividend  out  32  unsigned dividend magnitude to divider, registered
- div_divisor  out  32  unsigned divisor magnitude to divider, registered
- div_en  out  1  start request to divider
- div_flush  out  1  drives divider flush_exception; returns divider from DONE to IDLE
- div_quotient  in  32  divider quotient; valid while div_ready
- div_remainder  in  32  divider remainder; valid while div_ready
- div_ready  in  1  divider in DONE state; stays high until div_flush

## Operation

States: IDLE, BUSY, RESP, ABORT, RECOVER.

- **IDLE**
  - On ex_div_valid & ~flush: capture op, sign flags and operand magnitudes.
    - Signed ops (ex_op[1]=0): magnitude = two's-complement negate if bit 31 set; 0x80000000 stays 0x80000000.
    - Unsigned ops: operands pass through unchanged.
  - ex_src2==0: set bypass; go to RESP with result = 0 (div) or ex_src1 (mod). Divider is never touched.
  - Otherwise go to BUSY.
- **BUSY**
  - div_en=1.
  - On div_ready: register the corrected result, go to RESP.
    - Quotient is negated iff signed & (s1^s2).
    - Remainder is negated iff signed & s1.
    - Result is truncated to 32 bits.
  - On flush (priority over div_ready): go to ABORT.
- **RESP**
  - result_valid=1.
  - div_flush = ~bypass.
  - Next state: RECOVER if ~bypass, else IDLE.
  - A flush in RESP still lets result_valid stand; EX discards it.
- **ABORT**
  - div_en=0, no result.
  - On div_ready: pulse div_flush, go to RECOVER.
- **RECOVER**
  - One cycle, div_en=0, lets the divider reach IDLE.
  - Next state: IDLE.
  - Requests here are not captured; stall stays high.
- **Outputs**
  - div_en is high only in BUSY.
  - div_flush is high only in RESP (non-bypass) or on ABORT's exit cycle.
  - div_dividend/div_divisor are stable from capture until the next capture.
- **Overflow:** div.w 0x80000000 / 0xFFFFFFFF → quotient 0x80000000, remainder 0. No trap.
- **Reset** (any state, mid-operation included):
  - state=IDLE.
  - result, div_dividend, div_divisor = 0.
  - result_valid, div_en, div_flush, bypass = 0.
  - A divider mid-operation is reset by its own reset.

## Timing

- **Request at T0 (IDLE):** operands registered at T0 edge.
  - Non-zero divisor: div_en high from T1.
  - Earliest div_ready at T2.
  - result_valid at T3.
  - RECOVER at T4; next capture possible at T5.
- **Bypass:** request at T0, result_valid at T1, IDLE at T2.
- **stall:**
  - High from the request cycle until result_valid is high.
  - Low in the result_valid cycle, so EX advances on that edge.
  - Low whenever flush=1.
- **Flush in BUSY:** stall drops the same cycle. div_flush is asserted exactly once, in the cycle ABORT sees div_ready. No result_valid.
- **Divider contract:** div_en is never asserted while div_ready=1 from a previous op.

## Test plan

- div.w 0xFFFFFFF9/2 → result 0xFFFFFFFD. mod.w same operands → 0xFFFFFFFF. stall high until result_valid, one div_flush pulse.
- div.wu 0xFFFFFFF9/2 → 0x7FFFFFFC. mod.wu → 0x00000001. div_dividend=0xFFFFFFF9 unmodified.
- div.w 0x1234/0 → 0 at T1. mod.w 0x1234/0 → 0x1234. div_en and div_flush never asserted.
- div.w 0x80000000/0xFFFFFFFF → 0x80000000. mod.w → 0. mod.w 7/0xFFFFFFFE → 1.
- flush one cycle into BUSY → stall low that cycle, no result_valid, single div_flush after div_ready, next op completes correctly after RECOVER.
- Two back-to-back div.w ops: second stalled through RECOVER, both results correct. rst asserted mid-BUSY → all outputs zero next cycle, then a fresh op completes normally.

Source files
------------

// File: rtl/div_issue_ctrl.sv
// Initiator side of the EX-stage divider handshake: operand sign handling, divider
// sequencing, result sign correction, divide-by-zero bypass and flush abort.
module div_issue_ctrl (
   input  logic        clk,
   input  logic        rst,
   input  logic        ex_div_valid,
   input  logic [1:0]  ex_op,
   input  logic [31:0] ex_src1,
   input  logic [31:0] ex_src2,
   input  logic        flush,
   output logic        stall,
   output logic [31:0] result,
   output logic        result_valid,
   output logic [31:0] div_dividend,
   output logic [31:0] div_divisor,
   output logic        div_en,
   output logic        div_flush,
   input  logic [31:0] div_quotient,
   input  logic [31:0] div_remainder,
   input  logic        div_ready
);

   typedef enum logic [2:0] {IDLE, BUSY, RESP, ABORT, RECOVER} state_t;

   state_t      state, state_nxt;
   logic        capture;
   logic        src2_zero;
   logic        src_signed;
   logic        is_mod_p0, is_signed_p0, s1_neg_p0, s2_neg_p0, bypass_p0;
   logic [31:0] dividend_p0, divisor_p0;
   logic [31:0] result_p1;
   logic [31:0] quo_fix, rem_fix;

   // Two's-complement negate when requested; 0x80000000 maps onto itself.
   function automatic logic [31:0] cond_negate(input logic signed [31:0] v, input logic neg);
      logic signed [31:0] n;
      n = -v;
      return neg ? n : v;
   endfunction

   assign src_signed = ~ex_op[1];
   assign src2_zero  = (ex_src2 == 32'd0);
   assign capture    = (state == IDLE) && ex_div_valid && !flush;
   assign quo_fix    = cond_negate(div_quotient,  is_signed_p0 & (s1_neg_p0 ^ s2_neg_p0));
   assign rem_fix    = cond_negate(div_remainder, is_signed_p0 & s1_neg_p0);

   always_comb begin
      state_nxt    = state;
      div_en       = 1'b0;
      div_flush    = 1'b0;
      result_valid = 1'b0;
      case (state)
         IDLE: begin
            if (capture)
               state_nxt = src2_zero ? RESP : BUSY;
         end
         BUSY: begin
            div_en = 1'b1;
            if (flush)
               state_nxt = ABORT;
            else if (div_ready)
               state_nxt = RESP;
         end
         RESP: begin
            result_valid = 1'b1;
            div_flush    = ~bypass_p0;
            state_nxt    = bypass_p0 ? IDLE : RECOVER;
         end
         ABORT: begin
            // Wait for the abandoned op to finish, then return the divider to idle.
            if (div_ready) begin
               div_flush = 1'b1;
               state_nxt = RECOVER;
            end
         end
         RECOVER: state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Capture stage (_p0) and result stage (_p1)
   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         is_mod_p0    <= 1'b0;
         is_signed_p0 <= 1'b0;
         s1_neg_p0    <= 1'b0;
         s2_neg_p0    <= 1'b0;
         bypass_p0    <= 1'b0;
         dividend_p0  <= 32'd0;
         divisor_p0   <= 32'd0;
         result_p1    <= 32'd0;
      end else begin
         state <= state_nxt;
         if (capture) begin
            is_mod_p0    <= ex_op[0];
            is_signed_p0 <= src_signed;
            s1_neg_p0    <= src_signed & ex_src1[31];
            s2_neg_p0    <= src_signed & ex_src2[31];
            bypass_p0    <= src2_zero;
            dividend_p0  <= cond_negate(ex_src1, src_signed & ex_src1[31]);
            divisor_p0   <= cond_negate(ex_src2, src_signed & ex_src2[31]);
            if (src2_zero)
               result_p1 <= ex_op[0] ? ex_src1 : 32'd0;
         end
         if ((state == BUSY) && !flush && div_ready)
            result_p1 <= is_mod_p0 ? rem_fix : quo_fix;
      end
   end

   assign stall        = ex_div_valid & ~flush & ~result_valid;
   assign result       = result_p1;
   assign div_dividend = dividend_p0;
   assign div_divisor  = divisor_p0;

endmodule

// File: tb/tb_div_issue_ctrl.sv
// Bench for div_issue_ctrl: behavioural iterative divider, result scoreboard,
// directed sequence covering signed/unsigned, zero divisor, overflow, flush and reset.
module tb_div_issue_ctrl;

   logic        clk = 1'b0;
   logic        rst, ex_div_valid, flush;
   logic [1:0]  ex_op;
   logic [31:0] ex_src1, ex_src2;
   logic        stall, result_valid, div_en, div_flush;
   logic [31:0] result, div_dividend, div_divisor;
   logic [31:0] div_quotient = 32'd0, div_remainder = 32'd0;
   logic        div_ready = 1'b0;

   int vectors = 0, miscompares = 0;
   int flush_cnt = 0, en_cnt = 0, rv_cnt = 0, contract_viol = 0;
   int lat = 0;
   logic en_prev = 1'b0;
   logic [31:0] exp_q[$];

   always #5 clk = ~clk;

   div_issue_ctrl dut (
      .clk(clk), .rst(rst), .ex_div_valid(ex_div_valid), .ex_op(ex_op),
      .ex_src1(ex_src1), .ex_src2(ex_src2), .flush(flush), .stall(stall),
      .result(result), .result_valid(result_valid), .div_dividend(div_dividend),
      .div_divisor(div_divisor), .div_en(div_en), .div_flush(div_flush),
      .div_quotient(div_quotient), .div_remainder(div_remainder), .div_ready(div_ready)
   );

   // Unsigned iterative divider: IDLE -> BUSY (lat cycles) -> DONE until flushed.
   typedef enum logic [1:0] {D_IDLE, D_BUSY, D_DONE} dst_t;
   dst_t dst = D_IDLE;
   int   dcnt = 0;

   always @(posedge clk) begin
      if (rst) begin
         dst       <= D_IDLE;
         div_ready <= 1'b0;
      end else begin
         case (dst)
            D_IDLE: if (div_en) begin
               div_quotient  <= (div_divisor != 0) ? div_dividend / div_divisor : 32'hFFFF_FFFF;
               div_remainder <= (div_divisor != 0) ? div_dividend % div_divisor : div_dividend;
               if (lat == 0) begin
                  dst       <= D_DONE;
                  div_ready <= 1'b1;
               end else begin
                  dst  <= D_BUSY;
                  dcnt <= lat;
               end
            end
            D_BUSY: if (dcnt <= 1) begin
               dst       <= D_DONE;
               div_ready <= 1'b1;
            end else dcnt <= dcnt - 1;
            D_DONE: if (div_flush) begin
               dst       <= D_IDLE;
               div_ready <= 1'b0;
            end
            default: dst <= D_IDLE;
         endcase
      end
   end

   always @(negedge clk) begin
      logic [31:0] e;
      if (div_en && !en_prev && div_ready) contract_viol++;
      en_prev = div_en;
      if (div_flush) flush_cnt++;
      if (div_en) en_cnt++;
      if (result_valid) begin
         rv_cnt++;
         vectors++;
         if (exp_q.size() == 0) begin
            miscompares++;
            $error("FAIL unexpected_result: observed %h expected no result_valid", result);
         end else begin
            e = exp_q.pop_front();
            assert (result === e) else begin
               miscompares++;
               $error("FAIL result: observed %h expected %h", result, e);
            end
         end
      end
   end

   function automatic logic [31:0] ref_div(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      longint sa, sb;
      longint unsigned ua, ub;
      if (b == 32'd0) return op[0] ? a : 32'd0;
      if (!op[1]) begin
         sa = longint'($signed(a));
         sb = longint'($signed(b));
         return op[0] ? 32'(sa % sb) : 32'(sa / sb);
      end
      ua = 64'(a);
      ub = 64'(b);
      return op[0] ? 32'(ua % ub) : 32'(ua / ub);
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Drive one op and hold it until stall releases; counts stall-high cycles.
   task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input int exp_cyc);
      int cyc = 0;
      bit done = 0;
      exp_q.push_back(exp);
      ex_div_valid = 1'b1;
      ex_op = op;
      ex_src1 = a;
      ex_src2 = b;
      for (int i = 0; i < 60 && !done; i++) begin
         @(negedge clk);
         if (!stall) done = 1;
         else cyc++;
      end
      chk("op_done", 32'(done), 32'd1);
      chk("rv_at_release", 32'(result_valid), 32'd1);
      chk("stall_cycles", 32'(cyc), 32'(exp_cyc));
      @(posedge clk);
      #1;
      ex_div_valid = 1'b0;
   endtask

   initial begin
      int f0, e0, r0, cyc_exp;
      logic [1:0] op;
      logic [31:0] a, b;
      rst = 1'b1; ex_div_valid = 1'b0; flush = 1'b0; ex_op = 2'b00;
      ex_src1 = 32'd0; ex_src2 = 32'd0;
      tick(3);
      chk("rst_result", result, 32'd0);
      chk("rst_rv", 32'(result_valid), 32'd0);
      chk("rst_en", 32'(div_en), 32'd0);
      chk("rst_flush", 32'(div_flush), 32'd0);
      chk("rst_dividend", div_dividend, 32'd0);
      chk("rst_divisor", div_divisor, 32'd0);
      rst = 1'b0;
      tick(1);

      // Signed divide and modulo with negative dividend
      f0 = flush_cnt;
      run_op(2'b00, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 3);
      tick(2);
      chk("divw_flush_once", 32'(flush_cnt - f0), 32'd1);
      chk("divw_dividend_mag", div_dividend, 32'd7);
      f0 = flush_cnt;
      run_op(2'b01, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 3);
      tick(2);
      chk("modw_flush_once", 32'(flush_cnt - f0), 32'd1);

      // Unsigned variants leave operands untouched
      lat = 2;
      run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 32'h7FFF_FFFC, 5);
      tick(2);
      chk("divwu_dividend_raw", div_dividend, 32'hFFFF_FFF9);
      run_op(2'b11, 32'hFFFF_FFF9, 32'd2, 32'h0000_0001, 5);
      tick(2);

      // Divide by zero bypass never touches the divider
      f0 = flush_cnt; e0 = en_cnt;
      run_op(2'b00, 32'h0000_1234, 32'd0, 32'd0, 1);
      tick(2);
      run_op(2'b01, 32'h0000_1234, 32'd0, 32'h0000_1234, 1);
      tick(2);
      chk("bypass_no_en", 32'(en_cnt - e0), 32'd0);
      chk("bypass_no_flush", 32'(flush_cnt - f0), 32'd0);

      // Overflow and negative divisor remainder
      lat = 0;
      run_op(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 3);
      tick(2);
      run_op(2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 3);
      tick(2);
      run_op(2'b01, 32'd7, 32'hFFFF_FFFE, 32'd1, 3);
      tick(2);

      // Flush one cycle into BUSY
      lat = 3;
      f0 = flush_cnt; e0 = en_cnt; r0 = rv_cnt;
      ex_div_valid = 1'b1; ex_op = 2'b00; ex_src1 = 32'd100; ex_src2 = 32'd3;
      tick(1);
      flush = 1'b1;
      @(negedge clk);
      chk("flush_stall_low", 32'(stall), 32'd0);
      @(posedge clk);
      #1;
      flush = 1'b0;
      ex_div_valid = 1'b0;
      for (int i = 0; i < 30 && (flush_cnt == f0); i++) @(negedge clk);
      tick(3);
      chk("abort_flush_once", 32'(flush_cnt - f0), 32'd1);
      chk("abort_no_rv", 32'(rv_cnt - r0), 32'd0);
      chk("abort_en_cycles", 32'(en_cnt - e0), 32'd1);
      run_op(2'b00, 32'd100, 32'd3, 32'd33, 6);
      tick(2);

      // Back-to-back: second op waits through RECOVER
      lat = 0;
      run_op(2'b00, 32'd100, 32'd7, 32'd14, 3);
      run_op(2'b00, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 4);
      tick(2);

      // Reset in the middle of BUSY
      lat = 5;
      ex_div_valid = 1'b1; ex_op = 2'b01; ex_src1 = 32'd55; ex_src2 = 32'd4;
      tick(2);
      ex_div_valid = 1'b0;
      rst = 1'b1;
      tick(1);
      chk("mid_rst_result", result, 32'd0);
      chk("mid_rst_en", 32'(div_en), 32'd0);
      chk("mid_rst_flush", 32'(div_flush), 32'd0);
      chk("mid_rst_rv", 32'(result_valid), 32'd0);
      chk("mid_rst_dividend", div_dividend, 32'd0);
      chk("mid_rst_divisor", div_divisor, 32'd0);
      rst = 1'b0;
      tick(1);
      lat = 1;
      run_op(2'b01, 32'd55, 32'd4, 32'd3, 4);
      tick(2);

      // Mixed patterns against the reference model
      for (int i = 0; i < 10; i++) begin
         op  = 2'($urandom_range(0, 3));
         a   = $urandom;
         b   = (i % 4 == 3) ? 32'd0 : ($urandom >> $urandom_range(0, 31));
         lat = $urandom_range(0, 3);
         cyc_exp = (b == 32'd0) ? 1 : 3 + lat;
         run_op(op, a, b, ref_div(op, a, b), cyc_exp);
         tick(2);
      end

      chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
      chk("divider_contract", 32'(contract_viol), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
